// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates on issue, collects ALU/LSB results, commits the head
// and flushes on branch mispredict. Define ROB_BYPASS_EN to forward same-cycle writebacks to the query ports.
module reorder_buffer #(
  parameter int ROB_POS_WID = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   issue,
  input  logic [4:0]             issue_rd,
  input  logic                   issue_is_branch,
  input  logic                   issue_is_store,
  input  logic [31:0]            issue_pred_pc,
  output logic [ROB_POS_WID-1:0] issue_rob_pos,
  output logic                   full,
  input  logic                   alu_valid,
  input  logic [ROB_POS_WID-1:0] alu_rob_pos,
  input  logic [31:0]            alu_val,
  input  logic [31:0]            alu_next_pc,
  input  logic                   lsb_valid,
  input  logic [ROB_POS_WID-1:0] lsb_rob_pos,
  input  logic [31:0]            lsb_val,
  input  logic [ROB_POS_WID-1:0] query1_pos,
  input  logic [ROB_POS_WID-1:0] query2_pos,
  output logic                   query1_ready,
  output logic [31:0]            query1_val,
  output logic                   query2_ready,
  output logic [31:0]            query2_val,
  output logic                   rob_commit,
  output logic [4:0]             rob_commit_rd,
  output logic [31:0]            rob_commit_val,
  output logic [ROB_POS_WID-1:0] rob_commit_rob_pos,
  output logic                   commit_store,
  output logic                   rollback,
  output logic [31:0]            rollback_pc
);

  localparam int ROB_SIZE = 1 << ROB_POS_WID;
  localparam int CNT_W    = ROB_POS_WID + 1;
  localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]       CNT_MAX  = CNT_W'(ROB_SIZE);
  localparam logic [CNT_W-1:0]       CNT_THR  = CNT_W'(ROB_SIZE - 1);
  localparam logic [ROB_POS_WID-1:0] POS_ONE  = ROB_POS_WID'(1);

  logic        busy_q      [ROB_SIZE];
  logic        ready_q     [ROB_SIZE];
  logic [4:0]  rd_q        [ROB_SIZE];
  logic [31:0] val_q       [ROB_SIZE];
  logic        is_branch_q [ROB_SIZE];
  logic        is_store_q  [ROB_SIZE];
  logic [31:0] pred_pc_q   [ROB_SIZE];
  logic [31:0] real_pc_q   [ROB_SIZE];

  logic [ROB_POS_WID-1:0] head_q, tail_q;
  logic [CNT_W-1:0]       count_q;

  logic issue_fire, alu_fire, lsb_fire, commit_fire, mispredict;

  // Rollback cycle blocks everything younger than the flushed branch.
  assign issue_fire  = issue && !rollback && (count_q != CNT_MAX);
  assign alu_fire    = alu_valid && !rollback && busy_q[alu_rob_pos];
  assign lsb_fire    = lsb_valid && !rollback && busy_q[lsb_rob_pos] &&
                       !(alu_valid && (alu_rob_pos == lsb_rob_pos));
  assign commit_fire = (count_q != '0) && ready_q[head_q] && !rollback;
  assign mispredict  = commit_fire && is_branch_q[head_q] &&
                       (real_pc_q[head_q] != pred_pc_q[head_q]);

  assign issue_rob_pos = tail_q;
  assign full          = (count_q >= CNT_THR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
      end
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      rob_commit         <= 1'b0;
      rob_commit_rd      <= '0;
      rob_commit_val     <= '0;
      rob_commit_rob_pos <= '0;
      commit_store       <= 1'b0;
      rollback           <= 1'b0;
      rollback_pc        <= '0;
    end else if (rdy) begin
      rob_commit   <= commit_fire;
      commit_store <= commit_fire && is_store_q[head_q];
      rollback     <= mispredict;
      if (commit_fire) begin
        rob_commit_rd      <= rd_q[head_q];
        rob_commit_val     <= val_q[head_q];
        rob_commit_rob_pos <= head_q;
      end
      if (mispredict) begin
        rollback_pc <= real_pc_q[head_q];
        for (int i = 0; i < ROB_SIZE; i++) begin
          busy_q[i]  <= 1'b0;
          ready_q[i] <= 1'b0;
        end
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (alu_fire) begin
          ready_q[alu_rob_pos]   <= 1'b1;
          val_q[alu_rob_pos]     <= alu_val;
          real_pc_q[alu_rob_pos] <= alu_next_pc;
        end
        if (lsb_fire) begin
          ready_q[lsb_rob_pos] <= 1'b1;
          val_q[lsb_rob_pos]   <= lsb_val;
        end
        // Clear after writeback so a late strobe cannot leave a stale ready bit on a freed slot.
        if (commit_fire) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + POS_ONE;
        end
        if (issue_fire) begin
          busy_q[tail_q]      <= 1'b1;
          ready_q[tail_q]     <= 1'b0;
          rd_q[tail_q]        <= issue_rd;
          is_branch_q[tail_q] <= issue_is_branch;
          is_store_q[tail_q]  <= issue_is_store;
          pred_pc_q[tail_q]   <= issue_pred_pc;
          tail_q              <= tail_q + POS_ONE;
        end
        case ({issue_fire, commit_fire})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_comb begin
    query1_ready = ready_q[query1_pos];
    query1_val   = val_q[query1_pos];
    query2_ready = ready_q[query2_pos];
    query2_val   = val_q[query2_pos];
`ifdef ROB_BYPASS_EN
    // LSB first so a colliding ALU result overrides it.
    if (lsb_fire && (lsb_rob_pos == query1_pos)) begin
      query1_ready = 1'b1;
      query1_val   = lsb_val;
    end
    if (alu_fire && (alu_rob_pos == query1_pos)) begin
      query1_ready = 1'b1;
      query1_val   = alu_val;
    end
    if (lsb_fire && (lsb_rob_pos == query2_pos)) begin
      query2_ready = 1'b1;
      query2_val   = lsb_val;
    end
    if (alu_fire && (alu_rob_pos == query2_pos)) begin
      query2_ready = 1'b1;
      query2_val   = alu_val;
    end
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: stimulus pushes expected commits/rollbacks,
// a negedge monitor pops and compares them whenever the DUT pulses.
module tb_reorder_buffer;

`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue, issue_is_branch, issue_is_store;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pred_pc;
  logic [3:0]  issue_rob_pos;
  logic        full;
  logic        alu_valid, lsb_valid;
  logic [3:0]  alu_rob_pos, lsb_rob_pos;
  logic [31:0] alu_val, lsb_val, alu_next_pc;
  logic [3:0]  query1_pos, query2_pos;
  logic        query1_ready, query2_ready;
  logic [31:0] query1_val, query2_val;
  logic        rob_commit, commit_store, rollback;
  logic [4:0]  rob_commit_rd;
  logic [31:0] rob_commit_val, rollback_pc;
  logic [3:0]  rob_commit_rob_pos;

  reorder_buffer #(.ROB_POS_WID(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue(issue), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
    .issue_is_store(issue_is_store), .issue_pred_pc(issue_pred_pc),
    .issue_rob_pos(issue_rob_pos), .full(full),
    .alu_valid(alu_valid), .alu_rob_pos(alu_rob_pos), .alu_val(alu_val), .alu_next_pc(alu_next_pc),
    .lsb_valid(lsb_valid), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
    .query1_pos(query1_pos), .query2_pos(query2_pos),
    .query1_ready(query1_ready), .query1_val(query1_val),
    .query2_ready(query2_ready), .query2_val(query2_val),
    .rob_commit(rob_commit), .rob_commit_rd(rob_commit_rd), .rob_commit_val(rob_commit_val),
    .rob_commit_rob_pos(rob_commit_rob_pos), .commit_store(commit_store),
    .rollback(rollback), .rollback_pc(rollback_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  pos;
    logic        st;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  tail_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && rdy) begin
      if (rob_commit) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: got pos 0x%0h val 0x%0h expected no commit",
                   rob_commit_rob_pos, rob_commit_val);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("commit_rd",    32'(rob_commit_rd),      32'(e.rd));
          chk("commit_val",   rob_commit_val,          e.val);
          chk("commit_pos",   32'(rob_commit_rob_pos), 32'(e.pos));
          chk("commit_store", 32'(commit_store),       32'(e.st));
        end
      end else if (commit_store) begin
        checks++; errors++;
        $display("FAIL stray_store: got commit_store=1 expected 0 without rob_commit");
      end
      if (rollback) begin
        if (rb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rollback: got pc 0x%0h expected no rollback", rollback_pc);
        end else begin
          chk("rollback_pc", rollback_pc, rb_q.pop_front());
        end
      end
    end
  end

  task automatic do_issue(input logic [4:0] rd, input logic br, input logic st,
                          input logic [31:0] pred, input bit push, input logic [31:0] val);
    chk("issue_pos", 32'(issue_rob_pos), 32'(tail_m));
    if (push) exp_q.push_back('{rd, val, tail_m, st});
    issue = 1'b1; issue_rd = rd; issue_is_branch = br; issue_is_store = st; issue_pred_pc = pred;
    tick();
    issue = 1'b0; issue_is_branch = 1'b0; issue_is_store = 1'b0;
    tail_m++;
  endtask

  task automatic wb_alu(input logic [3:0] pos, input logic [31:0] val, input logic [31:0] npc);
    alu_valid = 1'b1; alu_rob_pos = pos; alu_val = val; alu_next_pc = npc;
    tick();
    alu_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] prev;
    int n;
    rst = 1'b0; rdy = 1'b1; issue = 1'b0; issue_rd = '0; issue_is_branch = 1'b0;
    issue_is_store = 1'b0; issue_pred_pc = '0; alu_valid = 1'b0; alu_rob_pos = '0;
    alu_val = '0; alu_next_pc = '0; lsb_valid = 1'b0; lsb_rob_pos = '0; lsb_val = '0;
    query1_pos = '0; query2_pos = '0;
    prev = '0;

    // Reset
    tick(); tick();
    chk("rst_commit", 32'(rob_commit), 0);
    chk("rst_store", 32'(commit_store), 0);
    chk("rst_rollback", 32'(rollback), 0);
    chk("rst_rb_pc", rollback_pc, 0);
    chk("rst_rd", 32'(rob_commit_rd), 0);
    chk("rst_val", rob_commit_val, 0);
    chk("rst_pos", 32'(rob_commit_rob_pos), 0);
    chk("rst_issue_pos", 32'(issue_rob_pos), 0);
    chk("rst_full", 32'(full), 0);
    rst = 1'b1;
    tick();

    // Basic issue -> writeback -> commit latency
    do_issue(5'd5, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234);
    alu_valid = 1'b1; alu_rob_pos = 4'd0; alu_val = 32'h1234; query1_pos = 4'd0;
    #1;
    chk("query_wb_cycle", 32'(query1_ready), 32'(BYP));
    tick();
    alu_valid = 1'b0;
    chk("no_early_commit", 32'(rob_commit), 0);
    chk("query_after_wb", 32'(query1_ready), 1);
    tick();
    chk("commit_latency", 32'(rob_commit), 1);
    tick();
    chk("commit_one_cycle", 32'(rob_commit), 0);

    // Store with rd=0 via LSB
    do_issue(5'd0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h55);
    lsb_valid = 1'b1; lsb_rob_pos = 4'd1; lsb_val = 32'h55;
    tick();
    lsb_valid = 1'b0;
    tick(); tick();

    // Fill to 15, write back in reverse, expect in-order burst
    for (int i = 0; i < 15; i++) begin
      do_issue(5'(i + 1), 1'b0, 1'b0, 32'h0, 1'b1, 32'(32'h100 + i));
      if (i == 13) chk("full_at_14", 32'(full), 0);
      if (i == 14) chk("full_at_15", 32'(full), 1);
    end
    for (int i = 14; i >= 0; i--) wb_alu(4'(2 + i), 32'(32'h100 + i), 32'h0);
    n = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (rob_commit) n++;
    end
    chk("burst_commits", 32'(n), 15);
    tick();
    chk("burst_end", 32'(rob_commit), 0);

    // Mispredicted branch with ready younger entries
    do_issue(5'd7, 1'b1, 1'b0, 32'h100, 1'b1, 32'h44);
    do_issue(5'd8, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    do_issue(5'd9, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    wb_alu(4'd2, 32'h88, 32'h0);
    wb_alu(4'd3, 32'h99, 32'h0);
    rb_q.push_back(32'h200);
    wb_alu(4'd1, 32'h44, 32'h200);
    tick();
    chk("rollback_pulse", 32'(rollback), 1);
    chk("rollback_tail", 32'(issue_rob_pos), 0);
    tail_m = '0;
    issue = 1'b1; issue_rd = 5'd31;
    tick();
    issue = 1'b0;
    chk("rollback_one_cycle", 32'(rollback), 0);
    chk("issue_dropped", 32'(issue_rob_pos), 0);

    // Correctly predicted branch, then ALU/LSB collision on pos 3
    do_issue(5'd6, 1'b1, 1'b0, 32'h300, 1'b1, 32'h66);
    wb_alu(4'd0, 32'h66, 32'h300);
    do_issue(5'd10, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    do_issue(5'd11, 1'b0, 1'b0, 32'h0, 1'b1, 32'h11);
    do_issue(5'd12, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA);
    wb_alu(4'd1, 32'h10, 32'h0);
    wb_alu(4'd2, 32'h11, 32'h0);
    alu_valid = 1'b1; alu_rob_pos = 4'd3; alu_val = 32'hA; alu_next_pc = 32'h0;
    lsb_valid = 1'b1; lsb_rob_pos = 4'd3; lsb_val = 32'hB; query1_pos = 4'd3;
    #1;
    chk("collide_q_ready", 32'(query1_ready), 32'(BYP));
    if (BYP) chk("collide_q_val", query1_val, 32'hA);
    tick();
    alu_valid = 1'b0; lsb_valid = 1'b0;
    chk("collide_arr_ready", 32'(query1_ready), 1);
    chk("collide_arr_val", query1_val, 32'hA);
    tick(); tick();

    // rdy=0 freezes commit and issue
    do_issue(5'd14, 1'b0, 1'b0, 32'h0, 1'b1, 32'h77);
    wb_alu(4'd4, 32'h77, 32'h0);
    rdy = 1'b0; issue = 1'b1; issue_rd = 5'd20;
    tick(); tick(); tick();
    chk("frozen_commit", 32'(rob_commit), 0);
    chk("frozen_tail", 32'(issue_rob_pos), 32'(tail_m));
    issue = 1'b0; rdy = 1'b1;
    tick();
    chk("unfrozen_commit", 32'(rob_commit), 1);
    tick();

    // 20 back-to-back issue/writeback pairs wrapping the tail
    for (int k = 0; k < 20; k++) begin
      chk("wrap_pos", 32'(issue_rob_pos), 32'(tail_m));
      exp_q.push_back('{5'(k + 1), 32'(32'h1000 + k), tail_m, 1'b0});
      issue = 1'b1; issue_rd = 5'(k + 1); issue_is_branch = 1'b0; issue_is_store = 1'b0;
      if (k > 0) begin
        alu_valid = 1'b1; alu_rob_pos = prev; alu_val = 32'(32'h1000 + k - 1);
      end
      tick();
      prev = tail_m;
      tail_m++;
    end
    issue = 1'b0;
    wb_alu(prev, 32'h1013, 32'h0);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    chk("drain_commits", 32'(exp_q.size()), 0);
    chk("drain_rollbacks", 32'(rb_q.size()), 0);

    // Reset mid-flight: ready entry must not commit
    do_issue(5'd3, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    wb_alu(prev + 4'd1, 32'h33, 32'h0);
    rst = 1'b0;
    tick();
    chk("midrst_commit", 32'(rob_commit), 0);
    chk("midrst_tail", 32'(issue_rob_pos), 0);
    rst = 1'b1;
    tick();
    chk("midrst_after", 32'(rob_commit), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
